zprize_div_seq: RTL and testbench
=================================

ZPRIZE_DIV_SEQ -- requirements
Module: zprize_div_seq

Interface
REQ-001 SHALL have parameter W, default 24: divisor width; dividend and quotient are 2W bits.
REQ-002 SHALL have parameter M, default 32: metadata width, carried unchanged from input to output.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: an operand set is offered.
REQ-006 SHALL have port in_ready, output, 1: the block accepts an operand set this cycle.
REQ-007 SHALL have port dividend, input, 2W: unsigned dividend.
REQ-008 SHALL have port divisor, input, W: unsigned divisor.
REQ-009 SHALL have port m_i, input, M: metadata tagged to the operand set.
REQ-010 SHALL have port out_valid, output, 1: a result is presented.
REQ-011 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-012 SHALL have port quot, output, 2W: quotient.
REQ-013 SHALL have port rem, output, W: remainder.
REQ-014 SHALL have port div0, output, 1: the result came from a zero divisor.
REQ-015 SHALL have port m_o, output, M: metadata of the presented result.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE and SHALL keep at most one operation in flight.
REQ-018 SHALL accept an operand set on the rising edge where in_valid=1 and in_ready=1, capturing dividend, divisor and m_i.
REQ-019 SHALL ignore in_valid and input data in CALC and DONE.
REQ-020 SHALL, on acceptance with divisor!=0, enter CALC with an iteration counter loaded to 2W-1.
REQ-021 SHALL, in CALC, perform one radix-2 restoring step per cycle, MSB first:
  - shift the partial remainder (W+1 bits) left and bring in the next dividend bit;
  - subtract the divisor if the result is >= 0 and set the quotient bit.
REQ-022 SHALL stay in CALC for exactly 2W cycles and enter DONE when the counter reaches 0.
REQ-023 SHALL assert out_valid exactly 2W+1 cycles after the accepting edge (49 cycles for W=24).
REQ-024 SHALL, on acceptance with divisor==0, skip CALC and enter DONE on the next edge with:
  - quot = all ones;
  - rem = dividend[W-1:0];
  - div0 = 1.
REQ-025 SHALL produce, for divisor!=0, results satisfying dividend == quot*divisor + rem with rem < divisor, and div0 = 0.
REQ-026 SHALL, in DONE, hold out_valid=1 and quot, rem, div0 and m_o stable until a rising edge with out_ready=1, then return to IDLE.
REQ-027 SHALL drive out_valid=0 outside DONE.
REQ-028 SHALL drive m_o equal to the captured m_i; metadata is never modified.
REQ-029 SHALL give in_ready=1 no earlier than the cycle after the output handshake; no same-cycle out/in overlap.

Reset
REQ-030 SHALL, while rst=0, asynchronously force the following, regardless of clk:
  - FSM to IDLE and counter to 0;
  - out_valid, quot, rem, div0 and m_o to 0;
  - in_ready to 0.
REQ-031 SHALL drive in_ready=1 on the first cycle after rst deasserts.
REQ-032 SHALL, when reset is asserted mid-CALC or in DONE, discard the operation silently and produce no result after release.

Verification
REQ-033 SHALL cover basic division: W=24, dividend=100, divisor=7, m_i=0xA5A5A5A5 -> out_valid 49 cycles after accept; quot=14, rem=2, div0=0, m_o=0xA5A5A5A5.
REQ-034 SHALL cover the extreme operands: dividend=2^48-1, divisor=2^24-1 -> quot=2^24+1, rem=0; also dividend=5, divisor=9 -> quot=0, rem=5.
REQ-035 SHALL cover divide-by-zero: dividend=0x123456789ABC, divisor=0 -> out_valid 1 cycle after accept; quot=0xFFFFFFFFFFFF, rem=0x789ABC, div0=1.
REQ-036 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
REQ-037 SHALL cover busy input: in_valid held high with changing data during CALC -> only the first set is processed; the second set is accepted only after the output handshake.
REQ-038 SHALL cover reset mid-operation: rst=0 at CALC cycle 10 -> all outputs 0 immediately; after release in_ready=1 and no stale out_valid appears.

Source files
------------

// File: rtl/zprize_div_seq.sv
// rtl/zprize_div_seq.sv - sequential radix-2 restoring divider, 2W/W unsigned, with metadata
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand set offered          in_ready  block idle and accepting
//   dividend   2W-bit unsigned dividend     divisor   W-bit unsigned divisor
//   m_i        M-bit metadata, passed through to m_o unchanged
//   out_valid  result presented (held until out_ready)
//   out_ready  consumer takes the result
//   quot/rem   2W-bit quotient, W-bit remainder
//   div0       result came from a zero divisor (quot all ones, rem = dividend[W-1:0])
//   m_o        metadata captured with the operand set
module zprize_div_seq #(
    parameter int W = 24,
    parameter int M = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    input  logic [M-1:0]     m_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   quot,
    output logic [W-1:0]     rem,
    output logic             div0,
    output logic [M-1:0]     m_o
);

    localparam int CW = $clog2(2 * W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]  cnt;
    logic [W:0]     pr;     // partial remainder
    logic [2*W-1:0] q;      // dividend bits shift out the top, quotient bits shift in below
    logic [W-1:0]   dvs;
    logic           dz;
    logic [M-1:0]   meta;

    logic           accept;
    logic [W+1:0]   pr_sh;
    logic [W+1:0]   diff;

    assign accept = in_valid && in_ready;

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor; the sign of the difference decides whether to keep it.
    always_comb begin
        pr_sh = {pr, q[2*W-1]};
        diff  = pr_sh - {2'b00, dvs};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; in_ready is gated by rst so it reads 0 while reset is held
    // even though the state register already sits in IDLE.
    always_comb begin
        in_ready  = (state == IDLE) && rst;
        out_valid = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            pr   <= '0;
            q    <= '0;
            dvs  <= '0;
            dz   <= 1'b0;
            meta <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        meta <= m_i;
                        dvs  <= divisor;
                        if (divisor == '0) begin
                            q   <= '1;
                            pr  <= {1'b0, dividend[W-1:0]};
                            dz  <= 1'b1;
                            cnt <= '0;
                        end else begin
                            q   <= dividend;
                            pr  <= '0;
                            dz  <= 1'b0;
                            cnt <= CW'(2 * W - 1);
                        end
                    end
                end
                CALC: begin
                    if (!diff[W+1]) begin
                        pr <= diff[W:0];
                        q  <= {q[2*W-2:0], 1'b1};
                    end else begin
                        pr <= pr_sh[W:0];
                        q  <= {q[2*W-2:0], 1'b0};
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quot = q;
    assign rem  = pr[W-1:0];
    assign div0 = dz;
    assign m_o  = meta;

endmodule

// File: tb/tb_zprize_div_seq.sv
// tb/tb_zprize_div_seq.sv - self-checking bench for zprize_div_seq
module tb_zprize_div_seq;

    localparam int W = 24;
    localparam int M = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2*W-1:0]   dividend = '0;
    logic [W-1:0]     divisor = '0;
    logic [M-1:0]     m_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   quot;
    logic [W-1:0]     rem;
    logic             div0;
    logic [M-1:0]     m_o;

    int tests = 0;
    int fails = 0;

    zprize_div_seq #(.W(W), .M(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .m_i      (m_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem),
        .div0     (div0),
        .m_o      (m_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [M-1:0]   meta;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dz;
        int             lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, offers one set, returns just after the accepting edge.
    task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                            input logic [M-1:0] meta);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait_in_ready", {63'd0, in_ready}, 64'd1);
        dividend = dvd;
        divisor  = dvs;
        m_i      = meta;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accepting edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input vec_t v);
        int lat;
        start_op(v.dvd, v.dvs, v.meta);
        wait_done(lat);
        check({tag, "_lat"},  64'(lat), 64'(v.lat));
        check({tag, "_quot"}, 64'(quot), 64'(v.q));
        check({tag, "_rem"},  64'(rem), 64'(v.r));
        check({tag, "_div0"}, 64'(div0), 64'(v.dz));
        check({tag, "_m_o"},  64'(m_o), 64'(v.meta));
        handshake;
        check({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_in_ready"},  64'(in_ready), 64'd1);
    endtask

    // Reference: plain arithmetic, plus the zero-divisor rule.
    function automatic vec_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                                   input logic [M-1:0] meta);
        vec_t v;
        v.dvd  = dvd;
        v.dvs  = dvs;
        v.meta = meta;
        if (dvs == 0) begin
            v.q   = {2*W{1'b1}};
            v.r   = dvd[W-1:0];
            v.dz  = 1'b1;
            v.lat = 1;
        end else begin
            v.q   = dvd / {{W{1'b0}}, dvs};
            v.r   = W'(dvd % {{W{1'b0}}, dvs});
            v.dz  = 1'b0;
            v.lat = 2 * W + 1;
        end
        return v;
    endfunction

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   lat;
        logic ok;
        logic [2*W-1:0] sq;
        logic [W-1:0]   sr;
        logic           sd;
        logic [M-1:0]   sm;

        vecs[0] = '{48'd100, 24'd7, 32'hA5A5A5A5, 48'd14, 24'd2, 1'b0, 49};
        vecs[1] = '{48'hFFFFFFFFFFFF, 24'hFFFFFF, 32'h00000001, 48'h000001000001, 24'd0, 1'b0, 49};
        vecs[2] = '{48'd5, 24'd9, 32'hDEADBEEF, 48'd0, 24'd5, 1'b0, 49};
        vecs[3] = '{48'h123456789ABC, 24'd0, 32'h0BADF00D, 48'hFFFFFFFFFFFF, 24'h789ABC, 1'b1, 1};
        vecs[4] = '{48'd0, 24'd3, 32'h12345678, 48'd0, 24'd0, 1'b0, 49};
        vecs[5] = '{48'hFFFFFFFFFFFF, 24'd1, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 24'd0, 1'b0, 49};

        // Reset state, checked while reset is held and before any clock edge matters.
        #12;
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quot",      64'(quot), 64'd0);
        check("rst_rem",       64'(rem), 64'd0);
        check("rst_div0",      64'(div0), 64'd0);
        check("rst_m_o",       64'(m_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Randomized operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [2*W-1:0] dvd;
            logic [W-1:0]   dvs;
            int mode;
            mode = $urandom_range(0, 5);
            dvd  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) dvd = 48'($urandom_range(0, 1000));
            case (mode)
                0:       dvs = '0;
                1:       dvs = W'($urandom_range(1, 255));
                default: dvs = W'($urandom);
            endcase
            if (mode > 1 && dvs == 0) dvs = 24'd1;
            run_and_check($sformatf("rnd%0d", i), model(dvd, dvs, $urandom));
        end

        // Backpressure: result held stable with in_ready low for 10 cycles.
        v = model(48'h00ABCDEF0123, 24'h000777, 32'hCAFEF00D);
        start_op(v.dvd, v.dvs, v.meta);
        wait_done(lat);
        check("bp_lat", 64'(lat), 64'(v.lat));
        sq = quot; sr = rem; sd = div0; sm = m_o;
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || quot !== sq || rem !== sr || div0 !== sd || m_o !== sm)
                ok = 1'b0;
        end
        check("bp_stable", 64'(ok), 64'd1);
        check("bp_quot", 64'(quot), 64'(v.q));
        check("bp_rem",  64'(rem), 64'(v.r));
        handshake;
        check("bp_post_out_valid", 64'(out_valid), 64'd0);
        check("bp_post_in_ready",  64'(in_ready), 64'd1);

        // Busy input: in_valid stays high with changing data during CALC.
        v = model(48'd1000000, 24'd3, 32'h11111111);
        start_op(v.dvd, v.dvs, v.meta);
        in_valid = 1'b1;
        ok  = 1'b1;
        lat = 1;
        while (!out_valid && lat < 200) begin
            dividend = {$urandom, $urandom};
            divisor  = W'($urandom) | 24'd1;
            m_i      = $urandom;
            if (in_ready) ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("busy_no_ready", 64'(ok), 64'd1);
        check("busy_a_lat",  64'(lat), 64'(v.lat));
        check("busy_a_quot", 64'(quot), 64'(v.q));
        check("busy_a_rem",  64'(rem), 64'(v.r));
        check("busy_a_m_o",  64'(m_o), 64'(v.meta));
        v = model(48'hFFFF00001234, 24'h010000, 32'h22222222);
        dividend = v.dvd;
        divisor  = v.dvs;
        m_i      = v.meta;
        check("busy_done_in_ready", 64'(in_ready), 64'd0);
        handshake;
        check("busy_post_in_ready", 64'(in_ready), 64'd1);
        check("busy_post_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(lat);
        check("busy_b_lat",  64'(lat), 64'(v.lat));
        check("busy_b_quot", 64'(quot), 64'h0000FFFF0000);
        check("busy_b_rem",  64'(rem), 64'h001234);
        check("busy_b_m_o",  64'(m_o), 64'h22222222);
        handshake;

        // Reset in CALC cycle 10: outputs clear asynchronously, no stale result.
        start_op(48'h0000DEADBEEF, 24'h0000FF, 32'h33333333);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready), 64'd0);
        check("midrst_quot",      64'(quot), 64'd0);
        check("midrst_rem",       64'(rem), 64'd0);
        check("midrst_div0",      64'(div0), 64'd0);
        check("midrst_m_o",       64'(m_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rel_in_ready", 64'(in_ready), 64'd1);
        ok = 1'b1;
        repeat (60) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        check("midrst_no_stale", 64'(ok), 64'd1);

        // Reset while in DONE also discards the result.
        start_op(48'd77, 24'd0, 32'h44444444);
        check("donerst_in_done", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("donerst_out_valid", 64'(out_valid), 64'd0);
        check("donerst_quot", 64'(quot), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        check("donerst_no_stale", 64'(ok), 64'd1);

        // Operation after reset recovery still works.
        run_and_check("after_rst", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
